// File: rtl/rom_pipe.sv
// rtl/rom_pipe.sv - pipelined read-only lookup table with valid/ready request and response
//
// Parameters: DATA_W (word width), ADDR_W (address width), DEPTH (implemented words),
//             LATENCY (accept-to-response cycles, 1..4), INIT_FILE (image name; contents
//             are word[i] = (3*i+1) mod 2^DATA_W).
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   req_valid  read request present
//   req_addr   read address, sampled on accept
//   req_ready  request can be accepted this cycle
//   rsp_valid  response word valid
//   rsp_ready  consumer accepts the response
//   rsp_data   read data (0 for out-of-range reads)
//   rsp_err    requested address was >= DEPTH
//   rsp_par    even parity of rsp_data (only with ROM_PARITY_EN defined)
//   busy       at least one pipeline stage holds a valid entry
// Optional feature macro: ROM_PARITY_EN.

module rom_pipe #(
    parameter int    DATA_W    = 4,
    parameter int    ADDR_W    = 4,
    parameter int    DEPTH     = 16,
    parameter int    LATENCY   = 2,
    parameter string INIT_FILE = ""
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    input  logic [ADDR_W-1:0] req_addr,
    output logic              req_ready,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_data,
    output logic              rsp_err,
`ifdef ROM_PARITY_EN
    output logic              rsp_par,
`endif
    output logic              busy
);

    // Stages after the memory read; LATENCY=1 reads straight into the output stage.
    localparam int NDS = (LATENCY > 1) ? LATENCY - 1 : 1;
    // One extra bit so DEPTH == 2^ADDR_W is representable.
    localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W + 1)'(DEPTH);

    logic stall;
    logic accept;

    assign stall     = rsp_valid & ~rsp_ready;
    assign req_ready = ~stall;
    assign accept    = req_valid & req_ready;

    // Entry presented to the memory read this cycle.
    logic              rd_valid;
    logic [ADDR_W-1:0] rd_addr;
    logic              rd_err;
    logic              s1_valid;

    generate
        if (LATENCY == 1) begin : g_direct
            assign rd_valid = accept;
            assign rd_addr  = req_addr;
            assign rd_err   = ({1'b0, req_addr} >= DEPTH_L);
            assign s1_valid = 1'b0;
        end else begin : g_stage1
            logic              v;
            logic [ADDR_W-1:0] a;
            logic              e;

            // Idle cycles load a bubble; a stall freezes the stage.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    v <= 1'b0;
                    a <= '0;
                    e <= 1'b0;
                end else if (!stall) begin
                    v <= accept;
                    a <= req_addr;
                    e <= ({1'b0, req_addr} >= DEPTH_L);
                end
            end

            assign rd_valid = v;
            assign rd_addr  = a;
            assign rd_err   = e;
            assign s1_valid = v;
        end
    endgenerate

    logic [DATA_W-1:0] rom_word;
    logic [DATA_W-1:0] rd_word;

    // Arithmetic in DATA_W bits gives the mod 2^DATA_W wrap for free.
    assign rom_word = DATA_W'(rd_addr) * DATA_W'(3) + DATA_W'(1);

    // Out-of-range reads and bubbles carry zero data so nothing aliases.
    assign rd_word = (rd_valid && !rd_err) ? rom_word : '0;

    logic [NDS-1:0]             d_valid;
    logic [NDS-1:0]             d_err;
    logic [NDS-1:0][DATA_W-1:0] d_data;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            d_valid <= '0;
            d_err   <= '0;
            d_data  <= '0;
        end else if (!stall) begin
            d_valid[0] <= rd_valid;
            d_err[0]   <= rd_valid & rd_err;
            d_data[0]  <= rd_word;
            for (int i = 1; i < NDS; i++) begin
                d_valid[i] <= d_valid[i-1];
                d_err[i]   <= d_err[i-1];
                d_data[i]  <= d_data[i-1];
            end
        end
    end

`ifdef ROM_PARITY_EN
    // Parity is derived from the zero-gated word, so out-of-range reads yield 0.
    logic [NDS-1:0] d_par;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            d_par <= '0;
        end else if (!stall) begin
            d_par[0] <= ^rd_word;
            for (int i = 1; i < NDS; i++) begin
                d_par[i] <= d_par[i-1];
            end
        end
    end

    assign rsp_par = d_par[NDS-1];
`endif

    assign rsp_valid = d_valid[NDS-1];
    assign rsp_err   = d_err[NDS-1];
    assign rsp_data  = d_data[NDS-1];
    assign busy      = s1_valid | (|d_valid);

endmodule

// File: tb/tb_rom_pipe.sv
// tb/tb_rom_pipe.sv - directed self-checking bench for rom_pipe

module tb_rom_pipe;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       req_valid = 1'b0;
    logic [3:0] req_addr = '0;
    logic       rsp_ready = 1'b1;

    logic [3:0] rr, rv, er, bz;
    logic [3:0] rd [4];
`ifdef ROM_PARITY_EN
    logic [3:0] rp;
`endif

    int n_vec  = 0;
    int n_fail = 0;

    // dut0: L2/D16, dut1: L2/D10, dut2: L1/D16, dut3: L4/D16
    int         lat_exp [4]    = '{1, 1, 0, 3};
    logic [3:0] va      [5]    = '{4'hA, 4'hB, 4'hC, 4'h9, 4'h0};
    logic [3:0] e16     [5]    = '{4'hF, 4'h2, 4'h5, 4'hC, 4'h1};
    logic [3:0] e10     [5]    = '{4'h0, 4'h0, 4'h0, 4'hC, 4'h1};
    logic       err10   [5]    = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    logic [3:0] stream_exp [16] = '{4'h1, 4'h4, 4'h7, 4'hA, 4'hD, 4'h0, 4'h3, 4'h6,
                                    4'h9, 4'hC, 4'hF, 4'h2, 4'h5, 4'h8, 4'hB, 4'hE};
    logic [3:0] bp_exp  [6]    = '{4'h4, 4'h7, 4'hA, 4'hD, 4'h0, 4'h3};

    always #5 clk = ~clk;

    for (genvar g = 0; g < 4; g++) begin : g_dut
        rom_pipe #(
            .DEPTH   ((g == 1) ? 10 : 16),
            .LATENCY ((g == 2) ? 1 : ((g == 3) ? 4 : 2))
        ) u_dut (
            .clk       (clk),
            .rst_n     (rst_n),
            .req_valid (req_valid),
            .req_addr  (req_addr),
            .req_ready (rr[g]),
            .rsp_valid (rv[g]),
            .rsp_ready (rsp_ready),
            .rsp_data  (rd[g]),
            .rsp_err   (er[g]),
`ifdef ROM_PARITY_EN
            .rsp_par   (rp[g]),
`endif
            .busy      (bz[g])
        );
    end

    task automatic test_reset();
        int cnt [4];
        #12;
        n_vec++;
        if (rv !== 4'h0 || bz !== 4'h0 || er !== 4'h0 || rr !== 4'hF) begin
            n_fail++;
            $display("FAIL reset_state: rv=%b bz=%b er=%b rr=%b, expected 0000 0000 0000 1111", rv, bz, er, rr);
        end
        for (int d = 0; d < 4; d++) begin
            n_vec++;
            if (rd[d] !== 4'h0) begin
                n_fail++;
                $display("FAIL reset_data dut%0d: got %h expected 0", d, rd[d]);
            end
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        // two requests in flight, then reset mid-cycle
        req_valid = 1'b1; req_addr = 4'h3; rsp_ready = 1'b1;
        @(posedge clk); #1;
        req_addr = 4'h4;
        @(posedge clk); #1;
        req_valid = 1'b0;
        n_vec++;
        if (rv !== 4'b0111 || bz !== 4'hF) begin
            n_fail++;
            $display("FAIL inflight_before_reset: rv=%b bz=%b, expected 0111 1111", rv, bz);
        end
        #1 rst_n = 1'b0;
        #1;
        n_vec++;
        if (rv !== 4'h0 || bz !== 4'h0 || er !== 4'h0) begin
            n_fail++;
            $display("FAIL async_reset: rv=%b bz=%b er=%b, expected all 0", rv, bz, er);
        end
        for (int d = 0; d < 4; d++) begin
            n_vec++;
            if (rd[d] !== 4'h0) begin
                n_fail++;
                $display("FAIL async_reset_data dut%0d: got %h expected 0", d, rd[d]);
            end
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b1; req_addr = 4'h6;
        @(posedge clk); #1;
        req_valid = 1'b0;
        for (int d = 0; d < 4; d++) cnt[d] = 0;
        for (int k = 0; k < 8; k++) begin
            for (int d = 0; d < 4; d++) begin
                if (rv[d]) begin
                    cnt[d]++;
                    n_vec++;
                    if (rd[d] !== 4'h3) begin
                        n_fail++;
                        $display("FAIL post_reset_data dut%0d: got %h expected 3", d, rd[d]);
                    end
                end
            end
            @(posedge clk); #1;
        end
        for (int d = 0; d < 4; d++) begin
            n_vec++;
            if (cnt[d] != 1) begin
                n_fail++;
                $display("FAIL post_reset_count dut%0d: got %0d responses expected 1", d, cnt[d]);
            end
        end
    endtask

    task automatic test_basic();
        for (int v = 0; v < 5; v++) begin
            logic [3:0] ed [4];
            logic       ee [4];
            bit         seen [4];
            for (int d = 0; d < 4; d++) begin
                ed[d]   = (d == 1) ? e10[v] : e16[v];
                ee[d]   = (d == 1) ? err10[v] : 1'b0;
                seen[d] = 1'b0;
            end
            req_valid = 1'b1; req_addr = va[v]; rsp_ready = 1'b1;
            #1;
            n_vec++;
            if (rr !== 4'hF) begin
                n_fail++;
                $display("FAIL basic_req_ready addr %h: rr=%b expected 1111", va[v], rr);
            end
            @(posedge clk); #1;
            req_valid = 1'b0;
            for (int k = 0; k < 6; k++) begin
                for (int d = 0; d < 4; d++) begin
                    if (!seen[d] && rv[d]) begin
                        seen[d] = 1'b1;
                        n_vec++;
                        if (k != lat_exp[d] || rd[d] !== ed[d] || er[d] !== ee[d]) begin
                            n_fail++;
                            $display("FAIL basic dut%0d addr %h: lat %0d data %h err %b, expected lat %0d data %h err %b",
                                     d, va[v], k, rd[d], er[d], lat_exp[d], ed[d], ee[d]);
                        end
`ifdef ROM_PARITY_EN
                        n_vec++;
                        if (rp[d] !== ^ed[d]) begin
                            n_fail++;
                            $display("FAIL basic_parity dut%0d addr %h: got %b expected %b", d, va[v], rp[d], ^ed[d]);
                        end
`endif
                    end
                end
                @(posedge clk); #1;
            end
            for (int d = 0; d < 4; d++) begin
                n_vec++;
                if (!seen[d]) begin
                    n_fail++;
                    $display("FAIL basic_timeout dut%0d addr %h: no response, expected one", d, va[v]);
                end
            end
        end
    endtask

    task automatic test_stream();
        int first = -1;
        int last  = -1;
        int n     = 0;
        int n3    = 0;
        int n2    = 0;
        rsp_ready = 1'b1;
        for (int c = 0; c < 24; c++) begin
            req_valid = (c < 16);
            req_addr  = 4'(c);
            @(posedge clk); #1;
            if (rv[0]) begin
                if (first < 0) first = c;
                last = c;
                n_vec++;
                if (n < 16 && rd[0] !== stream_exp[n]) begin
                    n_fail++;
                    $display("FAIL stream_data #%0d: got %h expected %h", n, rd[0], stream_exp[n]);
                end
                n++;
            end
            if (rv[2]) n2++;
            if (rv[3]) n3++;
        end
        req_valid = 1'b0;
        n_vec++;
        if (n != 16 || first != 1 || last != 16) begin
            n_fail++;
            $display("FAIL stream_shape: count %0d first %0d last %0d, expected 16 1 16", n, first, last);
        end
        n_vec++;
        if (n2 != 16 || n3 != 16) begin
            n_fail++;
            $display("FAIL stream_other_latency: L1 count %0d L4 count %0d, expected 16 16", n2, n3);
        end
    endtask

    task automatic test_backpressure();
        int issued = 0;
        int got    = 0;
        bit acc;
        for (int c = 0; c < 20; c++) begin
            rsp_ready = !(c >= 2 && c < 5);
            req_valid = (issued < 6);
            req_addr  = 4'(issued + 1);
            #1;
            acc = req_valid & rr[0];
            if (c >= 2 && c < 5) begin
                n_vec++;
                if (rr[0] !== 1'b0 || rv[0] !== 1'b1 || rd[0] !== 4'h4 || bz[0] !== 1'b1) begin
                    n_fail++;
                    $display("FAIL stall_hold cycle %0d: rr=%b rv=%b data=%h busy=%b, expected 0 1 4 1",
                             c, rr[0], rv[0], rd[0], bz[0]);
                end
            end
            if (rv[0] && rsp_ready) begin
                n_vec++;
                if (got >= 6) begin
                    n_fail++;
                    $display("FAIL bp_duplicate: extra response %h, expected none", rd[0]);
                end else if (rd[0] !== bp_exp[got]) begin
                    n_fail++;
                    $display("FAIL bp_order #%0d: got %h expected %h", got, rd[0], bp_exp[got]);
                end
                got++;
            end
            @(posedge clk); #1;
            if (acc) issued++;
        end
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        n_vec++;
        if (got != 6 || issued != 6) begin
            n_fail++;
            $display("FAIL bp_count: retired %0d issued %0d, expected 6 6", got, issued);
        end
        for (int k = 0; k < 8; k++) begin
            @(posedge clk); #1;
        end
        n_vec++;
        if (bz !== 4'h0) begin
            n_fail++;
            $display("FAIL bp_drain: busy=%b expected 0000", bz);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_stream();
        test_backpressure();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, expected finish");
        $fatal(1, "watchdog");
    end

endmodule
